// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequences a bank of WIDTH toggle flip-flops as a programmable
// up/down counter with hold, stop, one-shot/auto-reload and done/wrap pulses.
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             up,
    input  logic             reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] T_vec,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, limit_q, limit_d, mask, target;
    logic             up_q, up_d, reload_q, reload_d, done_q, done_d, wrap_q, wrap_d;
    logic             term, carry;
    // Bit i toggles when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        carry = 1'b1;
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = carry;
            carry = carry & (up_q ? q_q[i] : ~q_q[i]);
        end
    end
    assign target = up_q ? limit_q : '0;
    assign term   = q_q == target;
    assign T_vec  = (state_q == RUN && !stop && !term && !hold) ? mask : '0;
    assign Q      = q_q;
    assign busy   = state_q == RUN;
    assign done   = done_q;
    assign wrap   = wrap_q;
    always_comb begin
        state_d  = state_q;
        q_d      = q_q ^ T_vec;
        up_d     = up_q;
        reload_d = reload_q;
        limit_d  = limit_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) begin
                state_d  = RUN;
                up_d     = up;
                reload_d = reload;
                limit_d  = limit;
                q_d      = up ? '0 : limit;
            end
            RUN: if (stop) begin
                state_d = IDLE;
            end else if (term && reload_q) begin
                q_d    = up_q ? '0 : limit_q;
                wrap_d = 1'b1;
            end else if (term) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (!R) begin
            state_q  <= IDLE;
            q_q      <= '0;
            up_q     <= 1'b0;
            reload_q <= 1'b0;
            limit_q  <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            up_q     <= up_d;
            reload_q <= reload_d;
            limit_q  <= limit_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: vector table, corner sequences and random stimulus against
// an integer counter model of the controller.
module tb_tff_count_ctrl;
    localparam int W = 4;
    logic         Clk = 1'b0;
    logic         R, start, stop, hold, up, reload;
    logic [W-1:0] limit, T_vec, Q;
    logic         busy, done, wrap;
    int           errors = 0, checks = 0;
    int           ms, cnt, lim;
    bit           mup, mrel, mdone, mwrap, mvalid = 0;

    typedef struct {
        logic r, st, sp, h, u, rl;
        logic [3:0] l, q, t;
        logic b, d, w;
    } vec_t;
    vec_t tbl[18];

    always #5 Clk = ~Clk;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .R(R), .start(start), .stop(stop), .hold(hold), .up(up),
        .reload(reload), .limit(limit), .T_vec(T_vec), .Q(Q), .busy(busy),
        .done(done), .wrap(wrap)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic drive(input logic r, st, sp, h, u, rl, input logic [3:0] l);
        R = r; start = st; stop = sp; hold = h; up = u; reload = rl; limit = l;
    endtask

    function automatic int tgt();
        return mup ? lim : 0;
    endfunction

    // The bits that flip when the count moves one step are the toggle mask
    function automatic logic [W-1:0] exp_t();
        int nxt;
        if (ms != 1 || stop || hold || cnt == tgt()) return '0;
        nxt = mup ? cnt + 1 : cnt - 1;
        return W'(cnt ^ nxt);
    endfunction

    task automatic model_check();
        if (!mvalid) return;
        chk("m_q", 32'(Q), 32'(cnt));
        chk("m_busy", 32'(busy), 32'(ms == 1));
        chk("m_done", 32'(done), 32'(mdone));
        chk("m_wrap", 32'(wrap), 32'(mwrap));
        chk("m_tvec", 32'(T_vec), 32'(exp_t()));
    endtask

    task automatic model_edge();
        bit nd = 0, nw = 0;
        if (!R) begin
            ms = 0; cnt = 0; lim = 0; mup = 0; mrel = 0; mvalid = 1;
        end else if (ms == 0) begin
            if (start && !stop) begin
                ms = 1; mup = up; mrel = reload; lim = int'(limit);
                cnt = up ? 0 : int'(limit);
            end
        end else if (ms == 1) begin
            if (stop) ms = 0;
            else if (cnt == tgt()) begin
                if (mrel) begin cnt = mup ? 0 : lim; nw = 1; end
                else begin ms = 2; nd = 1; end
            end else if (!hold) cnt = mup ? cnt + 1 : cnt - 1;
        end else ms = 0;
        mdone = nd; mwrap = nw;
    endtask

    task automatic tick();
        #1 model_check();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    initial begin
        tbl[0]  = '{1,1,0,0,1,0,4'd5, 4'd0,4'd0, 0,0,0};
        tbl[1]  = '{1,0,0,0,1,0,4'd0, 4'd0,4'd1, 1,0,0};
        tbl[2]  = '{1,0,0,0,0,1,4'd0, 4'd1,4'd3, 1,0,0};
        tbl[3]  = '{1,0,0,0,1,0,4'd0, 4'd2,4'd1, 1,0,0};
        tbl[4]  = '{1,0,0,0,1,0,4'd0, 4'd3,4'd7, 1,0,0};
        tbl[5]  = '{1,0,0,0,1,0,4'd0, 4'd4,4'd1, 1,0,0};
        tbl[6]  = '{1,0,0,0,1,0,4'd0, 4'd5,4'd0, 1,0,0};
        tbl[7]  = '{1,0,1,0,1,0,4'd0, 4'd5,4'd0, 0,1,0};
        tbl[8]  = '{1,1,1,0,1,0,4'd3, 4'd5,4'd0, 0,0,0};
        tbl[9]  = '{1,1,0,0,0,1,4'd2, 4'd5,4'd0, 0,0,0};
        tbl[10] = '{1,0,0,0,1,0,4'd9, 4'd2,4'd3, 1,0,0};
        tbl[11] = '{1,0,0,0,1,0,4'd9, 4'd1,4'd1, 1,0,0};
        tbl[12] = '{1,0,0,0,1,0,4'd9, 4'd0,4'd0, 1,0,0};
        tbl[13] = '{1,1,0,0,1,0,4'd9, 4'd2,4'd3, 1,0,1};
        tbl[14] = '{1,0,0,1,1,0,4'd9, 4'd1,4'd0, 1,0,0};
        tbl[15] = '{1,0,1,0,1,0,4'd9, 4'd1,4'd0, 1,0,0};
        tbl[16] = '{0,0,0,0,1,0,4'd0, 4'd1,4'd0, 0,0,0};
        tbl[17] = '{1,0,0,0,0,0,4'd0, 4'd0,4'd0, 0,0,0};

        drive(0,0,0,0,0,0,4'd0);
        @(negedge Clk);
        tick(); tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].h, tbl[i].u, tbl[i].rl, tbl[i].l);
            #1;
            chk($sformatf("v%0d_q", i), 32'(Q), 32'(tbl[i].q));
            chk($sformatf("v%0d_t", i), 32'(T_vec), 32'(tbl[i].t));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].d));
            chk($sformatf("v%0d_wrap", i), 32'(wrap), 32'(tbl[i].w));
            tick();
        end

        // limit=0 one-shot: done right after the first RUN cycle
        drive(1,1,0,0,1,0,4'd0); tick();
        drive(1,0,0,0,1,0,4'd0); tick();
        chk("lim0_done", 32'(done), 1);
        tick();
        chk("lim0_idle", 32'(busy), 0);

        // down from 9: never toggles past 0, one done pulse, Q stays 0
        drive(1,1,0,0,0,0,4'd9); tick();
        drive(1,0,0,0,0,0,4'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("down_done", 32'(done), 1);
        chk("down_q", 32'(Q), 0);
        tick(); tick();
        chk("down_hold_q", 32'(Q), 0);
        chk("down_done_once", 32'(done), 0);

        // hold 3 cycles at Q=3
        drive(1,1,0,0,1,0,4'd5); tick();
        drive(1,0,0,0,1,0,4'd0); tick(); tick(); tick();
        drive(1,0,0,1,1,0,4'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_t", 32'(T_vec), 0);
            tick();
            chk("hold_q", 32'(Q), 3);
        end
        drive(1,0,0,0,1,0,4'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("hold_done", 32'(done), 1);
        tick();

        // stop on the terminal cycle: no done, no wrap
        drive(1,1,0,0,1,0,4'd1); tick();
        drive(1,0,0,0,1,0,4'd0); tick();
        drive(1,0,1,0,1,0,4'd0); tick();
        drive(1,0,0,0,1,0,4'd0);
        chk("stopterm_busy", 32'(busy), 0);
        chk("stopterm_done", 32'(done), 0);
        chk("stopterm_q", 32'(Q), 1);
        tick();
        chk("stopterm_done2", 32'(done), 0);

        // limit=15 up reaches 15 without wrapping to 0
        drive(1,1,0,0,1,0,4'd15); tick();
        drive(1,0,0,0,1,0,4'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("lim15_q", 32'(Q), 15);
        tick();
        chk("lim15_done", 32'(done), 1);
        chk("lim15_nowrap", 32'(Q), 15);
        tick();

        // reset held for 2 edges mid-run
        drive(1,1,0,0,1,1,4'd9); tick();
        drive(1,0,0,0,1,0,4'd0); tick(); tick(); tick();
        drive(0,0,0,0,1,0,4'd0); tick(); tick();
        drive(1,0,0,0,1,0,4'd0); #1;
        chk("rst_q", 32'(Q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_t", 32'(T_vec), 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 1) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
